trig_monitor: RTL
=================

TRIG_MONITOR -- requirements
Module: trig_monitor

Interface
REQ-001 SHALL provide parameter WIN_LEN, default 256, observation window length in clk cycles (legal 2..256).
REQ-002 SHALL provide parameter THRESH, default 4, coincidences per window that raise the alarm (legal 1..255).
REQ-003 SHALL provide port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL provide port rst  input  1  asynchronous active-low reset.
REQ-005 SHALL provide port en  input  1  monitor enable.
REQ-006 SHALL provide ports r1, r2  input  1 each  observed rare-event signals.
REQ-007 SHALL provide port clr  input  1  synchronous clear of alarm and counters.
REQ-008 SHALL provide port alarm  output  1  suspicious trigger activity detected.
REQ-009 SHALL provide port event_cnt  output  8  coincidences counted in the current window.
REQ-010 SHALL provide port alarm_cnt  output  8  total alarm entries since reset, saturating at 255.
REQ-011 SHALL provide port state  output  2  FSM state: 00 IDLE, 01 WATCH, 10 ALARM.

Function
REQ-012 SHALL define coincidence as en && r1 && r2, sampled on the rising clk edge.
REQ-013 SHALL move IDLE -> WATCH on the first edge with en=1; win_cnt and event_cnt are 0 on entry.
REQ-014 SHALL, in WATCH, increment internal win_cnt each cycle, 0..WIN_LEN-1, and increment event_cnt on each coincidence, saturating at 255.
REQ-015 SHALL move WATCH -> ALARM on the edge sampling the THRESH-th coincidence of the window; alarm is 1 one cycle after that sample (latency 1).
REQ-016 SHALL, at win_cnt==WIN_LEN-1 with fewer than THRESH coincidences including that cycle, clear win_cnt and event_cnt and stay in WATCH.
REQ-017 SHALL give the threshold crossing priority over window rollover in the same cycle (ALARM entered, counters not cleared).
REQ-018 SHALL increment alarm_cnt by 1 on each WATCH -> ALARM transition, saturating at 255.
REQ-019 SHALL freeze event_cnt while in ALARM; further coincidences are ignored.
REQ-020 SHALL move WATCH -> IDLE when en=0, clearing win_cnt and event_cnt.
REQ-021 SHALL keep ALARM when en deasserts; the alarm is not maskable by en.
REQ-022 SHALL, on clr=1, clear win_cnt and event_cnt and go to WATCH if en=1 else IDLE, with clr taking priority over a coincidence sampled in the same cycle.
REQ-023 SHALL leave alarm_cnt unaffected by clr.
REQ-024 SHALL drive alarm = (state==ALARM), registered, with no combinational path from inputs to outputs.

Reset
REQ-025 SHALL, while rst=0, asynchronously force state=IDLE, alarm=0, event_cnt=0, alarm_cnt=0, and win_cnt=0.
REQ-026 SHALL abandon any in-progress window or alarm on reset assertion mid-operation and leave IDLE on the first edge after release with en=1.

Configuration
REQ-027 SHALL, with macro TRIG_MON_STICKY_EN defined, hold ALARM until clr=1 or reset.
REQ-028 SHALL, without TRIG_MON_STICKY_EN, also leave ALARM automatically after WIN_LEN cycles in ALARM, to WATCH with counters cleared if en=1, else to IDLE; clr still exits early.

Verification (WIN_LEN=16, THRESH=3)
REQ-029 SHALL check: rst=0 with random inputs -> all outputs 0 and state=00; release with en=1 -> state=01 next edge.
REQ-030 SHALL check: 3 coincidences at window cycles 2, 5, 9 -> alarm=1 at cycle 10, event_cnt=3, and alarm_cnt=1.
REQ-031 SHALL check: 2 coincidences per window for 4 windows -> alarm stays 0 and event_cnt returns to 0 after each cycle-15 rollover.
REQ-032 SHALL check: 3rd coincidence sampled at cycle 15 -> ALARM entered with event_cnt=3 (no rollover clear).
REQ-033 SHALL check: in ALARM, clr=1 with r1=r2=1 in the same cycle -> state=01, event_cnt=0, alarm=0 next edge, and alarm_cnt unchanged.
REQ-034 SHALL check: sticky build holds alarm=1 for 100 cycles without clr; non-sticky build drops alarm after exactly 16 cycles in ALARM.

Source files
------------

// File: rtl/trig_monitor.sv
// ============================================================================
// Module   : trig_monitor
// Brief    : Watches two rare-event inputs for coincidences and raises an
//            alarm when THRESH of them land inside one WIN_LEN-cycle window.
//            Define TRIG_MON_STICKY_EN to keep the alarm until clr/reset.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module trig_monitor #(
    parameter int WIN_LEN = 256,
    parameter int THRESH  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       r1,
    input  logic       r2,
    input  logic       clr,
    output logic       alarm,
    output logic [7:0] event_cnt,
    output logic [7:0] alarm_cnt,
    output logic [1:0] state
);

    localparam int            c_WW       = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam logic [c_WW-1:0] c_WIN_LAST = c_WW'(WIN_LEN - 1);
    localparam logic [7:0]    c_THRESH   = 8'(THRESH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_WATCH = 2'b01,
        S_ALARM = 2'b10
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [c_WW-1:0] r_win_cnt, w_win_nxt;
    logic [7:0]      r_event_cnt, w_event_nxt;
    logic [7:0]      r_alarm_cnt, w_alarm_nxt;
    logic            r_alarm;
    logic            w_coinc;
    logic [7:0]      w_ev_inc;

`ifndef TRIG_MON_STICKY_EN
    logic [c_WW-1:0] r_hold_cnt, w_hold_nxt;
`endif

    assign w_coinc  = en & r1 & r2;
    assign w_ev_inc = (r_event_cnt == 8'hFF) ? 8'hFF : r_event_cnt + 8'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_win_nxt   = r_win_cnt;
        w_event_nxt = r_event_cnt;
        w_alarm_nxt = r_alarm_cnt;
`ifndef TRIG_MON_STICKY_EN
        w_hold_nxt  = r_hold_cnt;
`endif
        if (clr) begin
            w_state_nxt = en ? S_WATCH : S_IDLE;
            w_win_nxt   = '0;
            w_event_nxt = '0;
`ifndef TRIG_MON_STICKY_EN
            w_hold_nxt  = '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (en) begin
                        w_state_nxt = S_WATCH;
                        w_win_nxt   = '0;
                        w_event_nxt = '0;
                    end
                end
                S_WATCH: begin
                    if (!en) begin
                        w_state_nxt = S_IDLE;
                        w_win_nxt   = '0;
                        w_event_nxt = '0;
                    end else if (w_coinc && (w_ev_inc >= c_THRESH)) begin
                        // Threshold wins over a rollover in the same cycle
                        w_state_nxt = S_ALARM;
                        w_event_nxt = w_ev_inc;
                        w_alarm_nxt = (r_alarm_cnt == 8'hFF) ? 8'hFF : r_alarm_cnt + 8'd1;
`ifndef TRIG_MON_STICKY_EN
                        w_hold_nxt  = '0;
`endif
                    end else if (r_win_cnt == c_WIN_LAST) begin
                        w_win_nxt   = '0;
                        w_event_nxt = '0;
                    end else begin
                        w_win_nxt = r_win_cnt + c_WW'(1);
                        if (w_coinc) begin
                            w_event_nxt = w_ev_inc;
                        end
                    end
                end
                S_ALARM: begin
`ifndef TRIG_MON_STICKY_EN
                    if (r_hold_cnt == c_WIN_LAST) begin
                        w_state_nxt = en ? S_WATCH : S_IDLE;
                        w_win_nxt   = '0;
                        w_event_nxt = '0;
                        w_hold_nxt  = '0;
                    end else begin
                        w_hold_nxt = r_hold_cnt + c_WW'(1);
                    end
`endif
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_win_nxt   = '0;
                    w_event_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_win_cnt   <= '0;
            r_event_cnt <= '0;
            r_alarm_cnt <= '0;
            r_alarm     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_win_cnt   <= w_win_nxt;
            r_event_cnt <= w_event_nxt;
            r_alarm_cnt <= w_alarm_nxt;
            r_alarm     <= (w_state_nxt == S_ALARM);
        end
    end

`ifndef TRIG_MON_STICKY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold_cnt <= '0;
        end else begin
            r_hold_cnt <= w_hold_nxt;
        end
    end
`endif

    assign alarm     = r_alarm;
    assign event_cnt = r_event_cnt;
    assign alarm_cnt = r_alarm_cnt;
    assign state     = r_state;

endmodule

`default_nettype wire
